// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that lends one shared I2C master to NUM_REQ buses, with a
// bus-idle guard period between grants and a forced release on grant timeout.
module i2c_bus_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic               timeout_pulse,
  output logic [7:0]         timeout_cnt,
  input  logic               m_sda_oe,
  input  logic               m_scl_oe,
  output logic               m_sda_in,
  output logic               m_scl_in,
  output logic [NUM_REQ-1:0] bus_sda_oe,
  output logic [NUM_REQ-1:0] bus_scl_oe,
  input  logic [NUM_REQ-1:0] bus_sda_in,
  input  logic [NUM_REQ-1:0] bus_scl_in
);

  localparam int          IW           = $clog2(NUM_REQ);
  localparam logic [7:0]  GUARD_LAST   = 8'(GUARD_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT, GUARD} state_t;

  state_t        state, state_next;
  logic [IW-1:0] ptr, gnt_idx, winner, cand_idx;
  logic          found, armed;
  logic [23:0]   grant_cnt;
  logic [7:0]    guard_cnt;
  logic          lines_idle, timed_out, release_now, forced;
  int            cand;

  assign lines_idle  = bus_sda_in[gnt_idx] & bus_scl_in[gnt_idx];
  assign timed_out   = (grant_cnt == TIMEOUT_LAST);
  assign release_now = done[gnt_idx] | ~req[gnt_idx] | timed_out;
  // A done or dropped request in the timeout cycle counts as a normal release.
  assign forced      = timed_out & ~done[gnt_idx] & req[gnt_idx];

  // Search upward from the last winner, wrapping, so every requester gets a turn.
  always_comb begin
    winner   = ptr;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IW'(cand);
      if (!found && req[cand_idx]) begin
        found  = 1'b1;
        winner = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (armed && found) state_next = GRANT;
      GRANT:   if (release_now) state_next = GUARD;
      GUARD:   if (lines_idle && guard_cnt == GUARD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // armed holds off arbitration for the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr           <= IW'(NUM_REQ - 1);
      gnt_idx       <= '0;
      armed         <= 1'b0;
      grant_cnt     <= '0;
      guard_cnt     <= '0;
      timeout_pulse <= 1'b0;
      timeout_cnt   <= '0;
    end else begin
      armed         <= 1'b1;
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (state_next == GRANT) begin
            gnt_idx   <= winner;
            ptr       <= winner;
            grant_cnt <= '0;
          end
        end
        GRANT: begin
          grant_cnt <= grant_cnt + 24'd1;
          if (release_now) guard_cnt <= '0;
          if (forced) begin
            timeout_pulse <= 1'b1;
            if (timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
          end
        end
        GUARD: guard_cnt <= lines_idle ? guard_cnt + 8'd1 : 8'd0;
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt        = '0;
    bus_sda_oe = '0;
    bus_scl_oe = '0;
    m_sda_in   = 1'b1;
    m_scl_in   = 1'b1;
    busy       = (state != IDLE);
    if (state == GRANT) begin
      gnt[gnt_idx]        = 1'b1;
      bus_sda_oe[gnt_idx] = m_sda_oe;
      bus_scl_oe[gnt_idx] = m_scl_oe;
      m_sda_in            = bus_sda_in[gnt_idx];
      m_scl_in            = bus_scl_in[gnt_idx];
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of grant ownership.
module tb_i2c_bus_arbiter;

  localparam int NR    = 3;
  localparam int GUARD = 16;
  localparam int TMO   = 100;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req, done, gnt, bus_sda_oe, bus_scl_oe, bus_sda_in, bus_scl_in;
  logic          busy, timeout_pulse, m_sda_oe, m_scl_oe, m_sda_in, m_scl_in;
  logic [7:0]    timeout_cnt;

  int assert_count = 0;
  int fail_count   = 0;

  // Model: owner >= 0 while a grant is held, guarding while waiting for idle lines.
  int owner, guard_bus, last_winner, age, quiet, tcnt;
  bit guarding, armed, pulse;

  i2c_bus_arbiter #(.NUM_REQ(NR), .GUARD_CYCLES(GUARD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done), .gnt(gnt), .busy(busy),
    .timeout_pulse(timeout_pulse), .timeout_cnt(timeout_cnt),
    .m_sda_oe(m_sda_oe), .m_scl_oe(m_scl_oe), .m_sda_in(m_sda_in), .m_scl_in(m_scl_in),
    .bus_sda_oe(bus_sda_oe), .bus_scl_oe(bus_scl_oe),
    .bus_sda_in(bus_sda_in), .bus_scl_in(bus_scl_in)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NR-1:0] req_v, input logic [NR-1:0] done_v);
    req  = req_v;
    done = done_v;
  endtask

  task automatic modelReset();
    owner = -1; guarding = 0; guard_bus = 0; last_winner = NR - 1;
    age = 0; quiet = 0; tcnt = 0; armed = 0; pulse = 0;
  endtask

  task automatic modelStep();
    bit expire;
    pulse = 0;
    if (!armed) begin
      armed = 1;
    end else if (owner >= 0) begin
      expire = (age + 1 == TMO);
      if (done[owner] || !req[owner] || expire) begin
        if (expire && !done[owner] && req[owner]) begin
          pulse = 1;
          if (tcnt < 255) tcnt++;
        end
        guard_bus = owner; owner = -1; guarding = 1; quiet = 0;
      end else begin
        age++;
      end
    end else if (guarding) begin
      if (bus_sda_in[guard_bus] && bus_scl_in[guard_bus]) begin
        quiet++;
        if (quiet == GUARD) guarding = 0;
      end else begin
        quiet = 0;
      end
    end else begin
      for (int i = 1; i <= NR; i++) begin
        if (owner < 0 && req[(last_winner + i) % NR]) begin
          owner = (last_winner + i) % NR;
          last_winner = owner;
          age = 0;
        end
      end
    end
  endtask

  task automatic compareAll();
    logic [NR-1:0] e_gnt, e_sda, e_scl;
    logic e_msda, e_mscl;
    e_gnt = '0; e_sda = '0; e_scl = '0; e_msda = 1'b1; e_mscl = 1'b1;
    if (owner >= 0) begin
      e_gnt[owner] = 1'b1;
      e_sda[owner] = m_sda_oe;
      e_scl[owner] = m_scl_oe;
      e_msda = bus_sda_in[owner];
      e_mscl = bus_scl_in[owner];
    end
    checkOutput("gnt", gnt, e_gnt);
    checkOutput("busy", busy, (owner >= 0) || guarding);
    checkOutput("timeout_pulse", timeout_pulse, pulse);
    checkOutput("timeout_cnt", timeout_cnt, tcnt);
    checkOutput("bus_sda_oe", bus_sda_oe, e_sda);
    checkOutput("bus_scl_oe", bus_scl_oe, e_scl);
    checkOutput("m_sda_in", m_sda_in, e_msda);
    checkOutput("m_scl_in", m_scl_in, e_mscl);
  endtask

  // Caller drives inputs at posedge+1; outputs are checked at posedge+3.
  task automatic stepCycle();
    #2;
    compareAll();
    @(posedge clk);
    if (reset) modelReset();
    else       modelStep();
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    modelReset();
    applyStimulus('0, '0);
    m_sda_oe = 1'b0; m_scl_oe = 1'b0;
    bus_sda_in = '1; bus_scl_in = '1;
    repeat (2) stepCycle();
    reset = 1'b0;
  endtask

  task automatic waitGrant(input int limit);
    for (int i = 0; i < limit && gnt == '0; i++) stepCycle();
  endtask

  initial begin
    int hold, since;
    logic [NR-1:0] prev;
    logic [NR-1:0] rr_exp [4];
    logic [NR-1:0] grants [$];
    int starts [$];

    @(posedge clk); #1;
    doReset();
    checkOutput("reset_gnt", gnt, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_tcnt", timeout_cnt, 0);
    checkOutput("reset_m_scl_in", m_scl_in, 1);

    // Single request from a settled IDLE: one-cycle grant latency and the mux.
    repeat (3) stepCycle();
    applyStimulus(3'b010, '0);
    stepCycle();
    checkOutput("single_gnt", gnt, 3'b010);
    m_scl_oe = 1'b1; bus_sda_in = 3'b101;
    #1;
    checkOutput("single_scl_oe", bus_scl_oe, 3'b010);
    checkOutput("single_m_sda_in", m_sda_in, 0);
    stepCycle();
    m_scl_oe = 1'b0; bus_sda_in = '1;
    applyStimulus('0, '0);
    repeat (20) stepCycle();

    // done on a non-granted index is ignored.
    applyStimulus(3'b001, '0);
    waitGrant(5);
    checkOutput("ign_gnt_before", gnt, 3'b001);
    applyStimulus(3'b001, 3'b010);
    stepCycle();
    applyStimulus(3'b001, '0);
    checkOutput("ign_gnt_after", gnt, 3'b001);
    applyStimulus(3'b001, 3'b001);
    stepCycle();
    applyStimulus('0, '0);
    repeat (20) stepCycle();

    // Round-robin with all requests held and done five cycles into each grant.
    doReset();
    applyStimulus(3'b111, '0);
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
    since = -1; prev = '0;
    for (int cyc = 0; cyc < 200 && grants.size() < 4; cyc++) begin
      done = (since == 5) ? gnt : '0;
      stepCycle();
      if (gnt != '0 && prev == '0) begin
        grants.push_back(gnt);
        starts.push_back(cyc);
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      prev = gnt;
    end
    done = '0;
    checkOutput("rr_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) begin
      checkOutput("rr_order", grants[i], rr_exp[i]);
      if (i > 0) checkOutput("rr_gap", starts[i] - starts[i-1], 6 + GUARD + 1);
    end

    // Timeout: grant held exactly TMO cycles, then a one-cycle pulse.
    doReset();
    applyStimulus(3'b001, '0);
    waitGrant(5);
    hold = (gnt == 3'b001) ? 1 : 0;
    while (gnt == 3'b001 && hold < 150) begin
      stepCycle();
      if (gnt == 3'b001) hold++;
    end
    checkOutput("tmo_len", hold, TMO);
    checkOutput("tmo_pulse", timeout_pulse, 1);
    checkOutput("tmo_cnt", timeout_cnt, 1);
    stepCycle();
    checkOutput("tmo_pulse_end", timeout_pulse, 0);
    waitGrant(40);
    checkOutput("tmo_regrant", gnt, 3'b001);
    repeat (TMO - 1) stepCycle();
    applyStimulus(3'b001, 3'b001);
    stepCycle();
    applyStimulus(3'b001, '0);
    checkOutput("tmo_done_gnt", gnt, 0);
    checkOutput("tmo_done_pulse", timeout_pulse, 0);
    checkOutput("tmo_done_cnt", timeout_cnt, 1);

    // Guard hold: stuck-low SCL keeps the arbiter busy and grant-free.
    bus_scl_in = 3'b110;
    repeat (40) stepCycle();
    checkOutput("hold_busy", busy, 1);
    checkOutput("hold_gnt", gnt, 0);
    bus_scl_in = '1;
    repeat (GUARD) stepCycle();
    checkOutput("hold_idle_busy", busy, 0);
    stepCycle();
    checkOutput("hold_regrant", gnt, 3'b001);

    // Reset mid-grant releases the pull-downs immediately.
    doReset();
    applyStimulus(3'b100, '0);
    waitGrant(5);
    m_sda_oe = 1'b1;
    #1;
    checkOutput("rst_pre_oe", bus_sda_oe, 3'b100);
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("rst_async_oe", bus_sda_oe, 0);
    checkOutput("rst_async_gnt", gnt, 0);
    @(posedge clk); #1;
    stepCycle();
    m_sda_oe = 1'b0;
    reset = 1'b0;
    applyStimulus(3'b101, '0);
    stepCycle();
    checkOutput("rst_first_edge", gnt, 0);
    stepCycle();
    checkOutput("rst_first_winner", gnt, 3'b001);

    // Random traffic against the model.
    doReset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(7) == 0) req = NR'($urandom);
      done = ($urandom_range(15) == 0) ? NR'($urandom) : '0;
      m_sda_oe = 1'($urandom);
      m_scl_oe = 1'($urandom);
      for (int b = 0; b < NR; b++) begin
        bus_sda_in[b] = ($urandom_range(9) != 0);
        bus_scl_in[b] = ($urandom_range(9) != 0);
      end
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/i2c_bus_arbiter.md
I2C_BUS_ARBITER -- requirements
Module: i2c_bus_arbiter

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_REQ, default 3, giving the number of I2C buses and requesters (range 2..8).
REQ-002 The block SHALL have parameter GUARD_CYCLES, default 16, giving the consecutive bus-idle cycles required before a new grant (range 1..255).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1048576, giving the maximum grant length in clk cycles (range 2..2^24).

Ports (name, direction, width, meaning):
REQ-004 clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req  in  NUM_REQ  level request for the shared I2C master, one bit per bus.
REQ-007 done  in  NUM_REQ  one-cycle release pulse per requester.
REQ-008 gnt  out  NUM_REQ  registered one-hot grant (all zero when not granted).
REQ-009 busy  out  1  high in any state other than IDLE.
REQ-010 timeout_pulse  out  1  one-cycle pulse on a forced release.
REQ-011 timeout_cnt  out  8  saturating count of forced releases.
REQ-012 m_sda_oe, m_scl_oe  in  1 each  pull-low drive from the shared master.
REQ-013 m_sda_in, m_scl_in  out  1 each  line state of the granted bus, returned to the master.
REQ-014 bus_sda_oe, bus_scl_oe  out  NUM_REQ each  pull-low drive per bus (1 = drive low).
REQ-015 bus_sda_in, bus_scl_in  in  NUM_REQ each  line state per bus, already synchronised.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, GRANT and GUARD.
REQ-017 IDLE -> GRANT: in a cycle where req is nonzero, the winner SHALL be chosen round-robin, searching from index ptr+1 upward with wrap.
  - The winner's gnt bit SHALL be high on the next clk edge (1-cycle latency).
  - ptr SHALL be set to the winner's index.
REQ-018 In GRANT, with granted index k:
  - bus_sda_oe[k] SHALL equal m_sda_oe and bus_scl_oe[k] SHALL equal m_scl_oe, combinationally (0-cycle mux).
  - m_sda_in SHALL equal bus_sda_in[k] and m_scl_in SHALL equal bus_scl_in[k].
  - All other bus_*_oe bits SHALL be 0.
REQ-019 GRANT -> GUARD SHALL occur on the first of the following:
  - done[k] high;
  - req[k] low;
  - the grant cycle counter reaching TIMEOUT_CYCLES.
  gnt SHALL be all zero from the following cycle.
REQ-020 A timeout release SHALL pulse timeout_pulse for exactly one cycle and increment timeout_cnt, which saturates at 255.
  - If done[k] arrives in the same cycle as the timeout, the release SHALL be treated as normal, with no pulse and no increment.
REQ-021 done bits for non-granted indices SHALL be ignored in every state.
REQ-022 In GUARD and IDLE:
  - all bus_*_oe bits SHALL be 0;
  - m_sda_in and m_scl_in SHALL be 1.
REQ-023 GUARD SHALL count consecutive cycles in which both bus_sda_in[k] and bus_scl_in[k] are 1, clearing the count on any low.
  - GUARD -> IDLE SHALL occur when the count reaches GUARD_CYCLES.
  - A permanently stuck-low line SHALL hold the FSM in GUARD with busy=1, with no further grants.
REQ-024 A request asserted while the FSM is in GRANT or GUARD SHALL wait; it SHALL NOT be lost, since req is level-sensitive.
REQ-025 Round-robin fairness: with all req held high, grants SHALL rotate 0,1,2,0,... and no requester SHALL be granted twice while another waits.
REQ-026 The grant cycle counter SHALL be 24 bits wide and SHALL be cleared on every entry to GRANT.

Reset
REQ-027 While reset is high, and from its asynchronous assertion:
  - the state SHALL be IDLE and ptr SHALL be NUM_REQ-1, so index 0 wins first;
  - gnt, busy, timeout_pulse, timeout_cnt, counters and bus_*_oe SHALL be 0;
  - m_sda_in and m_scl_in SHALL be 1.
REQ-028 Reset asserted mid-GRANT SHALL release all bus_*_oe to 0 immediately (asynchronously), with no guard phase.
REQ-029 After reset deasserts, the first grant SHALL be possible on the second rising edge.

Verification
REQ-030 The bench SHALL cover these directed scenarios (defaults NUM_REQ=3, GUARD_CYCLES=16; TIMEOUT_CYCLES=100 where stated):
  - Single request: req=3'b010 at cycle 0 -> gnt=3'b010 at cycle 1; with m_scl_oe=1, bus_scl_oe=3'b010; with bus_sda_in[1]=0, m_sda_in=0.
  - Round-robin: req=3'b111 held, done[k] pulsed 5 cycles after each grant, lines idle high -> grant sequence 001,010,100,001, each separated by 1 + 16 guard cycles plus 1 IDLE cycle.
  - Timeout (TIMEOUT_CYCLES=100): req=3'b001 held, no done -> gnt falls after 100 grant cycles; timeout_pulse=1 for one cycle; timeout_cnt=1; done and timeout in the same cycle -> timeout_cnt unchanged.
  - Guard hold: in GUARD, bus_scl_in[k]=0 for 40 cycles -> no grant and busy=1; after release, exactly 16 idle cycles then IDLE, then the next grant.
  - Reset mid-grant: gnt=3'b100 with m_sda_oe=1, assert reset -> bus_sda_oe=0 in the same cycle; after deassert with req=3'b101 -> index 0 is granted first.
  - Ignored done: gnt=3'b001, pulse done=3'b010 -> gnt unchanged.
